alu_request_arbiter: RTL
========================

Name: alu_request_arbiter

Overview:
- Shares one 8-bit ALU datapath between two requesters. Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin and registers the winning opcode and operands. It holds them stable on the ALU-facing ports for a programmable number of cycles, then samples the result and carry.
- It screens illegal opcodes and divide-by-zero before they reach the ALU.
- It sits between the instruction-issue logic and the ALU instance.

Parameters:
- ALU_WAIT, 1, cycles operands are held on the ALU ports before the result is sampled. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- resetN  input  1  synchronous, active-low reset
- reqValid  input  2  per-requester request valid; bit i = requester i
- reqReady  output  2  per-requester request accept
- reqOpCode  input  8  {req1[3:0], req0[3:0]}
- reqOperandA  input  16  {req1[7:0], req0[7:0]}
- reqOperandB  input  16  {req1[7:0], req0[7:0]}
- rspValid  output  2  response valid, one-hot, owner only
- rspReady  input  2  per-requester response accept
- rspResult  output  8  shared response data
- rspCarryOut  output  1  shared carry/borrow
- rspError  output  1  1 = illegal opcode or DIV by zero
- aluOperandA  output  8  to ALU operandA
- aluOperandB  output  8  to ALU operandB
- aluOpCode  output  4  to ALU opCode
- aluResult  input  8  from ALU result, combinational
- aluCarryOut  input  1  from ALU carryOut
- busy  output  1  state != IDLE

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-low on resetN.
- Reset values: state=IDLE, lastGrant=1 (requester 0 wins the first tie), rspValid=00, rspResult=0x00, rspCarryOut=0, rspError=0, aluOperandA/B=0x00, aluOpCode=0000, busy=0.
- Reset gating: reqReady is forced 00 while resetN=0.
- States: IDLE, EXEC, RESP. 4-bit wait counter. Owner register is 1 bit.
- Arbitration (IDLE only, combinational):
  - Exactly one valid: grant that requester.
  - Both valid: grant the requester != lastGrant.
  - reqReady[grant]=1 only in IDLE with reqValid[grant]=1; all other reqReady bits are 0.
  - reqReady depends on reqValid. Requesters must not make reqValid depend on reqReady.
  - A requester holds valid and payload stable until accepted.
- Accept (reqValid&reqReady at an edge):
  - Latch the granted opCode/A/B into aluOpCode/aluOperandA/aluOperandB.
  - owner <= grant.
  - Error check on the incoming request: opCode 1110 or 1111, or opCode 0011 with operandB==0x00.
  - Error: go to RESP with rspResult=0x00, rspCarryOut=0, rspError=1. ALU port registers are still updated.
  - Otherwise: counter <= ALU_WAIT-1, go to EXEC.
- EXEC:
  - ALU ports are held constant.
  - Counter != 0: decrement.
  - Counter == 0: rspResult <= aluResult, rspCarryOut <= aluCarryOut, rspError <= 0, go to RESP.
  - Latency is ALU_WAIT cycles from the accept edge to rspValid high.
- RESP:
  - rspValid[owner]=1 and the other bit is 0.
  - rspResult, rspCarryOut and rspError are held stable until rspReady[owner]=1 at an edge.
  - On that edge: go to IDLE, lastGrant <= owner.
  - rspReady of the non-owner is ignored.
- ALU ports retain their last values in IDLE and RESP; they are not cleared after an operation.
- Throughput: no accept in EXEC or RESP. With immediate rspReady, the minimum spacing between accepts is ALU_WAIT+2 cycles.
- Carry: forwarded only as the ALU reports it. The block does not gate carry by opcode.
- Reset mid-operation: the operation is abandoned and no response is issued. The next cycle shows the reset values.

Test Plan:
1. ALU_WAIT=1, ALU model attached; req0 ADD (0000) A=0x7F B=0x01 -> aluOpCode=0000 at accept+1; rspValid=01, rspResult=0x80, rspCarryOut=0, rspError=0 one cycle after accept; busy=1 from accept to the response handshake.
2. Both reqValid held high after reset, rspReady=11 -> accept order req0, req1, req0, req1; each rspValid goes only to the matching owner; reqReady is never 11.
3. req1 DIV (0011) A=0x20 B=0x00 -> rspValid=10, rspResult=0x00, rspError=1 the cycle after accept, no EXEC cycle; then req0 opCode 1111 -> same error response on rspValid=01.
4. req0 SUB A=0x05 B=0x07, rspReady=00 for 5 cycles -> rspValid=01, rspResult=0xFE and carry held constant for all 5 cycles; reqReady=00 while req1 is valid; the response completes on rspReady=01.
5. ALU_WAIT=3, ALU stub whose output changes each cycle -> ALU ports are stable for 3 cycles, and rspResult equals the stub value in the 3rd EXEC cycle only.
6. resetN low for one cycle during EXEC (ALU_WAIT=4) -> the next cycle has all outputs at reset values, no rspValid is ever issued for that request, and the next tie is granted to req0.

Source files
------------

// File: rtl/alu_request_arbiter.sv
// Round-robin arbiter that lets two requesters share one 8-bit ALU.
// It screens illegal opcodes and divide-by-zero, and holds operands on the ALU for ALU_WAIT cycles.
module alu_request_arbiter #(
    parameter int ALU_WAIT = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [1:0]  reqValid,
    output logic [1:0]  reqReady,
    input  logic [7:0]  reqOpCode,
    input  logic [15:0] reqOperandA,
    input  logic [15:0] reqOperandB,
    output logic [1:0]  rspValid,
    input  logic [1:0]  rspReady,
    output logic [7:0]  rspResult,
    output logic        rspCarryOut,
    output logic        rspError,
    output logic [7:0]  aluOperandA,
    output logic [7:0]  aluOperandB,
    output logic [3:0]  aluOpCode,
    input  logic [7:0]  aluResult,
    input  logic        aluCarryOut,
    output logic        busy
);

    // Handshake: a transfer happens on any rising edge where valid and ready are both 1.
    // reqReady is a function of reqValid, so requesters must never wait on reqReady before raising valid.
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(ALU_WAIT - 1);

    state_t     state;
    logic       lastGrant;
    logic       owner;
    logic [3:0] waitCnt;

    logic       grant;
    logic       accept;
    logic       reqIllegal;
    logic [3:0] grantOpCode;
    logic [7:0] grantA;
    logic [7:0] grantB;

    always_comb begin
        grant       = (reqValid == 2'b11) ? ~lastGrant : reqValid[1];
        grantOpCode = grant ? reqOpCode[7:4]    : reqOpCode[3:0];
        grantA      = grant ? reqOperandA[15:8] : reqOperandA[7:0];
        grantB      = grant ? reqOperandB[15:8] : reqOperandB[7:0];
        reqIllegal  = (grantOpCode == 4'hE) || (grantOpCode == 4'hF) ||
                      ((grantOpCode == 4'h3) && (grantB == 8'h00));
        reqReady    = 2'b00;
        if (resetN && (state == IDLE) && reqValid[grant]) begin
            reqReady = grant ? 2'b10 : 2'b01;
        end
    end

    assign accept = |(reqValid & reqReady);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state       <= IDLE;
            lastGrant   <= 1'b1;
            owner       <= 1'b0;
            waitCnt     <= 4'd0;
            rspValid    <= 2'b00;
            rspResult   <= 8'h00;
            rspCarryOut <= 1'b0;
            rspError    <= 1'b0;
            aluOperandA <= 8'h00;
            aluOperandB <= 8'h00;
            aluOpCode   <= 4'h0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        aluOpCode   <= grantOpCode;
                        aluOperandA <= grantA;
                        aluOperandB <= grantB;
                        owner       <= grant;
                        busy        <= 1'b1;
                        // Rejected requests still load the ALU ports but skip execution.
                        if (reqIllegal) begin
                            rspResult   <= 8'h00;
                            rspCarryOut <= 1'b0;
                            rspError    <= 1'b1;
                            rspValid    <= grant ? 2'b10 : 2'b01;
                            state       <= RESP;
                        end else begin
                            waitCnt <= WAIT_LOAD;
                            state   <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (waitCnt != 4'd0) begin
                        waitCnt <= waitCnt - 4'd1;
                    end else begin
                        rspResult   <= aluResult;
                        rspCarryOut <= aluCarryOut;
                        rspError    <= 1'b0;
                        rspValid    <= owner ? 2'b10 : 2'b01;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rspReady[owner]) begin
                        rspValid  <= 2'b00;
                        busy      <= 1'b0;
                        lastGrant <= owner;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
